// File: rtl/glitch_seq.sv
// Glitch-window sequencer: arms on a config, waits for a synchronized trigger edge,
// then drives `cnt` high for N windows. Optional glitch counter: GLITCH_SEQ_STATS_EN.
module glitch_seq #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk_in1,
  input  logic               resetn,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [WIDTH_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               trigger,
  input  logic               abort,
  output logic               cnt,
  output logic               busy,
  output logic               done,
  output logic [15:0]        glitch_total,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_DELAY  = 3'd2,
    S_GLITCH = 3'd3,
    S_GAP    = 3'd4
  } state_e;

  // Config handshake: a config transfers in any cycle where cfg_valid && cfg_ready
  // (cfg_ready is high only in IDLE) and abort is low; fields are sampled that cycle.

  state_e              state_q, state_d;
  logic                trig_meta_q, trig_sync_q, trig_prev_q;
  logic                trig_rise;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [WIDTH_W-1:0]  width_q, width_d;
  logic [WIDTH_W-1:0]  gap_q, gap_d;
  logic [DELAY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [WIDTH_W-1:0]  len_cnt_q, len_cnt_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic                cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                accept;

  assign trig_rise = trig_sync_q & ~trig_prev_q;
  assign accept    = cfg_valid && (state_q == S_IDLE) && !abort;

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= trigger;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    width_d   = width_q;
    gap_d     = gap_q;
    dly_cnt_d = dly_cnt_q;
    len_cnt_d = len_cnt_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Zero width/gap are stored as 1 so the countdown logic never sees 0.
          delay_d = cfg_delay;
          width_d = (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
          gap_d   = (cfg_gap == '0) ? WIDTH_W'(1) : cfg_gap;
          rem_d   = cfg_count;
          if (cfg_count == '0) done_d  = 1'b1;
          else                 state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (trig_rise) begin
          len_cnt_d = width_q;
          dly_cnt_d = delay_q;
          state_d   = (delay_q == '0) ? S_GLITCH : S_DELAY;
        end
      end
      S_DELAY: begin
        dly_cnt_d = dly_cnt_q - DELAY_W'(1);
        if (dly_cnt_q == DELAY_W'(1)) begin
          state_d   = S_GLITCH;
          len_cnt_d = width_q;
        end
      end
      S_GLITCH: begin
        len_cnt_d = len_cnt_q - WIDTH_W'(1);
        if (len_cnt_q == WIDTH_W'(1)) begin
          if (rem_q > COUNT_W'(1)) begin
            state_d   = S_GAP;
            len_cnt_d = gap_q;
            rem_d     = rem_q - COUNT_W'(1);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        len_cnt_d = len_cnt_q - WIDTH_W'(1);
        if (len_cnt_q == WIDTH_W'(1)) begin
          state_d   = S_GLITCH;
          len_cnt_d = width_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      delay_d   = '0;
      width_d   = '0;
      gap_d     = '0;
      dly_cnt_d = '0;
      len_cnt_d = '0;
      rem_d     = '0;
    end
  end

  // cnt is registered from the next state so the mux select is a clean flop output.
  assign cnt_d = (state_d == S_GLITCH);

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      delay_q   <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      dly_cnt_q <= '0;
      len_cnt_q <= '0;
      rem_q     <= '0;
      cnt_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      dly_cnt_q <= dly_cnt_d;
      len_cnt_q <= len_cnt_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef GLITCH_SEQ_STATS_EN
  logic [15:0] total_q;

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      total_q <= '0;
    end else if (cnt_d && !cnt_q && (total_q != 16'hFFFF)) begin
      total_q <= total_q + 16'd1;
    end
  end

  assign glitch_total = total_q;
`else
  assign glitch_total = '0;
`endif

  assign cnt       = cnt_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign cfg_ready = (state_q == S_IDLE);
  assign state_dbg = state_q;

endmodule
